// File: rtl/muxed_sample_ring.sv
// muxed_sample_ring: per-channel recirculating sample rings; each head loads data_in on its capture phase
// and otherwise reloads from its tail, so the DUT input paths keep toggling deterministically.
module muxed_sample_ring #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 2,
  parameter int PERIOD   = 2,
  parameter int PHASE    = 0,
  parameter int STAGGER  = 0
) (
  input  logic                         pll_clock,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [CHANNELS*WIDTH-1:0]    data_in,
  output logic [CHANNELS*WIDTH-1:0]    data_out,
  output logic [CHANNELS-1:0]          capture
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  if (PERIOD < 1 || DEPTH < 1 || PHASE < 0 || PHASE >= PERIOD) begin : g_bad_params
    $error("muxed_sample_ring: need PERIOD>=1, DEPTH>=1, 0<=PHASE<PERIOD");
  end
  (* keep = "true", dont_touch = "true", preserve *) logic [CW-1:0] cnt;
  logic [CHANNELS-1:0] cap;
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (enable) cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge pll_clock or negedge reset_n) begin
    if (!reset_n) capture <= '0;
    else capture <= cap;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    // Normalised so a negative stagger still lands on a valid counter value.
    localparam int PH = ((PHASE + c * STAGGER) % PERIOD + PERIOD) % PERIOD;
    (* keep = "true", dont_touch = "true", shreg_extract = "no", preserve *) logic [WIDTH-1:0] s [DEPTH];
    assign cap[c] = enable & (cnt == CW'(PH));
    assign data_out[c*WIDTH +: WIDTH] = s[0];
    always_ff @(posedge pll_clock or negedge reset_n) begin
      if (!reset_n) s <= '{default: '0};
      else if (enable) begin
        s[0] <= cap[c] ? data_in[c*WIDTH +: WIDTH] : s[DEPTH-1];
        for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
      end
    end
  end
endmodule

// File: tb/tb_muxed_sample_ring.sv
// tb_muxed_sample_ring: directed checks of several muxed_sample_ring configurations sharing one clock.
module tb_muxed_sample_ring;
  logic clk = 0, reset_n = 0, enable = 0;
  logic [7:0] din = 0;
  logic [31:0] din4, o3;
  logic [7:0] o1, o2, o4, o5;
  logic c1, c2, c4, c5;
  logic [3:0] c3;
  int n_cmp = 0, n_err = 0;
  int t1[6] = '{0, 0, 2, 0, 4, 0};
  int t2[10] = '{0, 0, 2, 0, 4, 2, 6, 4, 8, 6};
  always #5 clk = ~clk;
  assign din4 = {din + 8'h30, din + 8'h20, din + 8'h10, din};
  muxed_sample_ring #(.WIDTH(8), .DEPTH(2), .PERIOD(2)) u1 (
    .pll_clock(clk), .reset_n(reset_n), .enable(enable), .data_in(din), .data_out(o1), .capture(c1));
  muxed_sample_ring #(.WIDTH(8), .DEPTH(3), .PERIOD(2)) u2 (
    .pll_clock(clk), .reset_n(reset_n), .enable(enable), .data_in(din), .data_out(o2), .capture(c2));
  muxed_sample_ring #(.WIDTH(8), .CHANNELS(4), .DEPTH(2), .PERIOD(4), .STAGGER(1)) u3 (
    .pll_clock(clk), .reset_n(reset_n), .enable(enable), .data_in(din4), .data_out(o3), .capture(c3));
  muxed_sample_ring #(.WIDTH(8), .DEPTH(2), .PERIOD(1)) u4 (
    .pll_clock(clk), .reset_n(reset_n), .enable(enable), .data_in(din), .data_out(o4), .capture(c4));
  muxed_sample_ring #(.WIDTH(8), .DEPTH(1), .PERIOD(3)) u5 (
    .pll_clock(clk), .reset_n(reset_n), .enable(enable), .data_in(din), .data_out(o5), .capture(c5));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Holds reset over two edges, checks the reset state, then releases between edges.
  task automatic do_reset;
    reset_n = 0;
    enable = 0;
    din = 0;
    tick;
    tick;
    check("rst_out1", o1, 0);
    check("rst_cap1", c1, 0);
    check("rst_out3", o3, 0);
    check("rst_cap3", c3, 0);
    check("rst_cnt3", u3.cnt, 0);
    reset_n = 1;
    enable = 1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    do_reset;
    for (int k = 0; k < 10; k++) begin
      din = 8'(k);
      tick;
      check("d2_out", o1, (k % 2 == 0) ? k : 0);
      check("d2_cap", c1, (k % 2 == 0) ? 1 : 0);
      check("d3_out", o2, t2[k]);
      check("ch_cap", c3, 1 << (k % 4));
      check("ch_out", o3[(k%4)*8 +: 8], 16 * (k % 4) + k);
      check("p1_out", o4, k);
      check("p1_cap", c4, 1);
      check("d1_out", o5, k - k % 3);
      check("d1_cap", c5, (k % 3 == 0) ? 1 : 0);
    end
    do_reset;
    for (int j = 0; j < 3; j++) begin
      din = 8'(j);
      tick;
    end
    check("pre_gap_out", o1, 2);
    enable = 0;
    din = 8'hff;
    for (int g = 0; g < 3; g++) begin
      tick;
      check("gap_out", o1, 2);
      check("gap_cap", c1, 0);
      check("gap_cnt", u1.cnt, 1);
    end
    enable = 1;
    for (int j = 3; j < 8; j++) begin
      din = 8'(j);
      tick;
      check("resume_out", o1, (j % 2 == 0) ? j : 0);
      check("resume_cap", c1, (j % 2 == 0) ? 1 : 0);
    end
    do_reset;
    for (int k = 0; k < 5; k++) begin
      din = 8'(k);
      tick;
    end
    check("pre_rst_out", o1, 4);
    check("pre_rst_cap", c1, 1);
    #3 reset_n = 0;
    #1;
    check("async_out", o1, 0);
    check("async_cap", c1, 0);
    check("async_out3", o2, 0);
    tick;
    check("held_out", o1, 0);
    reset_n = 1;
    for (int k = 0; k < 6; k++) begin
      din = 8'(k);
      tick;
      check("restart_out", o1, t1[k]);
      check("restart_cap", c1, (k % 2 == 0) ? 1 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
